// File: rtl/overture_io_pkg.sv
// rtl/overture_io_pkg.sv - shared widths, default depths and serve-FSM states for the OVERTURE I/O bridge
package overture_io_pkg;

  localparam int OVERTURE_BYTE_W   = 8;
  localparam int OVERTURE_RX_DEPTH = 16;
  localparam int OVERTURE_TX_DEPTH = 16;
  localparam logic [15:0] OVERTURE_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    IDLE,
    HOLD
  } serve_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == OVERTURE_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/overture_io_fifo.sv
// rtl/overture_io_fifo.sv - synchronous first-word-fall-through FIFO used for both bridge directions
module overture_io_fifo
  import overture_io_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = OVERTURE_BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/overture_io_bridge.sv
// rtl/overture_io_bridge.sv - OVERTURE core I/O port endpoint; event counters built only with OVERTURE_IO_STATS_EN
module overture_io_bridge
  import overture_io_pkg::*;
#(
  parameter int RX_DEPTH = OVERTURE_RX_DEPTH,
  parameter int TX_DEPTH = OVERTURE_TX_DEPTH,
  parameter logic [OVERTURE_BYTE_W-1:0] UNDERFLOW_BYTE = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arch_input_enable,
  output logic [OVERTURE_BYTE_W-1:0] arch_input_value,
  input  logic                       arch_output_enable,
  input  logic [OVERTURE_BYTE_W-1:0] arch_output_value,
  input  logic                       rx_valid,
  input  logic [OVERTURE_BYTE_W-1:0] rx_data,
  output logic                       rx_ready,
  output logic                       tx_valid,
  output logic [OVERTURE_BYTE_W-1:0] tx_data,
  input  logic                       tx_ready,
  output logic                       rx_underflow,
  output logic                       tx_overflow,
  output logic [15:0]                rx_underflow_cnt,
  output logic [15:0]                tx_drop_cnt
);

  serve_state_t               state;
  logic                       en_q;
  logic                       rx_pop;
  logic                       rx_full;
  logic                       rx_empty;
  logic [OVERTURE_BYTE_W-1:0] rx_head;
  logic                       rx_uf_evt;
  logic                       tx_pop;
  logic                       tx_full;
  logic                       tx_empty;
  logic                       tx_drop_evt;

  assign rx_pop    = (state == IDLE) && arch_input_enable && !en_q;
  assign rx_uf_evt = rx_pop && rx_empty;

  // rx_ready reflects occupancy only; a byte offered while full is still taken
  // when the core pops in that same cycle, keeping the FIFO full.
  assign rx_ready = !rx_full;

  overture_io_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (OVERTURE_BYTE_W)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign tx_valid    = !tx_empty;
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_drop_evt = arch_output_enable && tx_full && !tx_pop;

  overture_io_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (OVERTURE_BYTE_W)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (arch_output_enable),
    .push_data (arch_output_value),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      en_q             <= 1'b0;
      arch_input_value <= '0;
      rx_underflow     <= 1'b0;
    end else begin
      en_q <= arch_input_enable;
      case (state)
        IDLE: begin
          if (rx_pop) begin
            arch_input_value <= rx_empty ? UNDERFLOW_BYTE : rx_head;
            state            <= HOLD;
          end else begin
            arch_input_value <= '0;
          end
        end
        HOLD: begin
          if (!arch_input_enable) begin
            arch_input_value <= '0;
            state            <= IDLE;
          end
        end
        default: begin
          arch_input_value <= '0;
          state            <= IDLE;
        end
      endcase
      if (rx_uf_evt) rx_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              tx_overflow <= 1'b0;
    else if (tx_drop_evt) tx_overflow <= 1'b1;
  end

`ifdef OVERTURE_IO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_underflow_cnt <= '0;
      tx_drop_cnt      <= '0;
    end else begin
      if (rx_uf_evt)   rx_underflow_cnt <= sat_inc16(rx_underflow_cnt);
      if (tx_drop_evt) tx_drop_cnt      <= sat_inc16(tx_drop_cnt);
    end
  end
`else
  assign rx_underflow_cnt = '0;
  assign tx_drop_cnt      = '0;
`endif

endmodule

// File: tb/tb_overture_io_bridge.sv
// tb/tb_overture_io_bridge.sv - scoreboard bench for overture_io_bridge with a queue-based reference model
module tb_overture_io_bridge;

  localparam int RXD = 16;
  localparam int TXD = 16;
  localparam logic [7:0] UF_BYTE = 8'h00;

  logic        clk;
  logic        rst;
  logic        arch_input_enable;
  logic [7:0]  arch_input_value;
  logic        arch_output_enable;
  logic [7:0]  arch_output_value;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_underflow;
  logic        tx_overflow;
  logic [15:0] rx_underflow_cnt;
  logic [15:0] tx_drop_cnt;

  overture_io_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .arch_input_enable  (arch_input_enable),
    .arch_input_value   (arch_input_value),
    .arch_output_enable (arch_output_enable),
    .arch_output_value  (arch_output_value),
    .rx_valid           (rx_valid),
    .rx_data            (rx_data),
    .rx_ready           (rx_ready),
    .tx_valid           (tx_valid),
    .tx_data            (tx_data),
    .tx_ready           (tx_ready),
    .rx_underflow       (rx_underflow),
    .tx_overflow        (tx_overflow),
    .rx_underflow_cnt   (rx_underflow_cnt),
    .tx_drop_cnt        (tx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  aiv;
    logic        rdy;
    logic        tvld;
    logic        uf;
    logic        ov;
    logic [15:0] ucnt;
    logic [15:0] dcnt;
  } status_t;

  status_t    st_q[$];
  logic [7:0] exp_tx_q[$];

  logic [7:0]  m_rx_q[$];
  int          m_tx_cnt;
  logic        m_prev_en;
  logic [7:0]  m_val;
  logic        m_uf;
  logic        m_ov;
  logic [15:0] m_ucnt;
  logic [15:0] m_dcnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances to the state after the coming edge.
  task automatic drive(input logic r, input logic en, input logic oe, input logic [7:0] ov,
                       input logic rv, input logic [7:0] rd, input logic tr);
    status_t s;
    int      pre;
    bit      popped;
    @(negedge clk);
    rst = r; arch_input_enable = en; arch_output_enable = oe; arch_output_value = ov;
    rx_valid = rv; rx_data = rd; tx_ready = tr;
    if (r) begin
      m_rx_q.delete(); exp_tx_q.delete();
      m_tx_cnt = 0; m_prev_en = 1'b0; m_val = 8'h00;
      m_uf = 1'b0; m_ov = 1'b0; m_ucnt = 16'h0; m_dcnt = 16'h0;
    end else begin
      pre = m_rx_q.size();
      popped = 1'b0;
      if (en && !m_prev_en) begin
        if (pre == 0) begin
          m_val = UF_BYTE; m_uf = 1'b1;
          if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
        end else begin
          m_val = m_rx_q.pop_front(); popped = 1'b1;
        end
      end else if (!en) begin
        m_val = 8'h00;
      end
      m_prev_en = en;
      if (rv && (pre < RXD || popped)) m_rx_q.push_back(rd);

      pre = m_tx_cnt;
      popped = tr && (pre > 0);
      if (popped) m_tx_cnt--;
      if (oe) begin
        if (pre < TXD || popped) begin
          exp_tx_q.push_back(ov); m_tx_cnt++;
        end else begin
          m_ov = 1'b1;
          if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
        end
      end
    end
    s.aiv  = m_val;
    s.rdy  = (m_rx_q.size() < RXD);
    s.tvld = (m_tx_cnt > 0);
    s.uf   = m_uf;
    s.ov   = m_ov;
`ifdef OVERTURE_IO_STATS_EN
    s.ucnt = m_ucnt;
    s.dcnt = m_dcnt;
`else
    s.ucnt = 16'h0;
    s.dcnt = 16'h0;
`endif
    st_q.push_back(s);
  endtask

  task automatic idle(input int n, input logic tr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, tr);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Status monitor: compares DUT state just after each edge to the queued expectation.
  initial begin
    status_t s;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() == 0) begin
        chk("status_queue_empty", 16'd0, 16'd1);
      end else begin
        s = st_q.pop_front();
        chk("arch_input_value", {8'h00, arch_input_value}, {8'h00, s.aiv});
        chk("rx_ready", {15'h0, rx_ready}, {15'h0, s.rdy});
        chk("tx_valid", {15'h0, tx_valid}, {15'h0, s.tvld});
        chk("rx_underflow", {15'h0, rx_underflow}, {15'h0, s.uf});
        chk("tx_overflow", {15'h0, tx_overflow}, {15'h0, s.ov});
        chk("rx_underflow_cnt", rx_underflow_cnt, s.ucnt);
        chk("tx_drop_cnt", tx_drop_cnt, s.dcnt);
      end
    end
  end

  // Drain monitor: every accepted tx byte must match the scoreboard head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          chk("tx_unexpected_byte", {8'h00, tx_data}, 16'hFFFF);
        end else begin
          e = exp_tx_q.pop_front();
          chk("tx_data", {8'h00, tx_data}, {8'h00, e});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; arch_input_enable = 1'b0; arch_output_enable = 1'b0; arch_output_value = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

    do_reset();
    idle(1, 1'b0);

    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h42, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      idle(2, 1'b0);
    end

    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1, 1'b0);

    for (int i = 0; i < 18; i++) drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
    idle(18, 1'b1);

    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b1);
    idle(18, 1'b1);

    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h60 + i), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hEE, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      idle(1, 1'b0);
    end

    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(2, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      logic en;
      en = arch_input_enable;
      if ($urandom_range(0, 3) == 0) en = ~en;
      drive(($urandom_range(0, 399) == 0), en,
            ($urandom_range(0, 9) < 5), 8'($urandom),
            ($urandom_range(0, 9) < 4), 8'($urandom),
            ($urandom_range(0, 9) < 4));
    end

    idle(24, 1'b1);
    @(posedge clk);
    #3;
    chk("status_queue_drained", 16'(st_q.size()), 16'd0);
    chk("tx_scoreboard_drained", 16'(exp_tx_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
